// File: rtl/debounce_multi_pkg.sv
// debounce_pkg: shared constants and types for the multi-channel debouncer.
//   DB_DEFAULT_STABLE : default run length of disagreeing samples before a flip
//   db_evt_t          : per-channel edge event pair {rise, fall}
package debounce_pkg;

  localparam int unsigned DB_DEFAULT_STABLE = 4;

  typedef struct packed {
    logic rise;
    logic fall;
  } db_evt_t;

endpackage

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: bundles the debouncer's sampling inputs and clean outputs.
//   sample_tk : counter advance enable (tie high to count every clock)
//   raw_in    : asynchronous bouncy inputs, one bit per channel
//   db_state  : debounced level per channel
//   rise_pls  : 1-cycle pulse per channel on a 0->1 flip
//   fall_pls  : 1-cycle pulse per channel on a 1->0 flip
//   any_pls   : OR of all rise/fall pulses, aligned with them
// master drives raw_in/sample_tk; slave is the debouncer.
interface debounce_multi_if #(
  parameter int unsigned N_CH = 4
);
  logic            sample_tk;
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] db_state;
  logic [N_CH-1:0] rise_pls;
  logic [N_CH-1:0] fall_pls;
  logic            any_pls;

  modport master (
    output sample_tk, raw_in,
    input  db_state, rise_pls, fall_pls, any_pls
  );

  modport slave (
    input  sample_tk, raw_in,
    output db_state, rise_pls, fall_pls, any_pls
  );
endinterface

// File: rtl/debounce_multi_chan.sv
// debounce_chan: one debouncer channel.
//   clk, reset : system clock, async active-high reset
//   sample_tk  : counter advance enable
//   raw        : asynchronous bouncy input
//   state      : debounced level
//   evt        : registered {rise, fall} pulses, high the cycle after a flip edge
//   evt_nxt    : combinational value evt will load at the next edge
// A 2-flop synchroniser feeds a run-length counter; the level flips only after
// STABLE_CYCLES consecutive qualifying samples that disagree with it. Any sample
// that agrees clears the run.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DB_DEFAULT_STABLE,
  parameter logic        RESET_STATE   = 1'b0
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    sample_tk,
  input  logic    raw,
  output logic    state,
  output db_evt_t evt,
  output db_evt_t evt_nxt
);
  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             state_nxt;

  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    evt_nxt   = '0;
    if (sync1 == state) begin
      cnt_nxt = '0;
    end else if (sample_tk) begin
      if (cnt == CNT_LAST) begin
        // counter restarts on the flip, so it can never wrap
        state_nxt    = ~state;
        cnt_nxt      = '0;
        evt_nxt.rise = ~state;
        evt_nxt.fall = state;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= RESET_STATE;
      sync1 <= RESET_STATE;
      state <= RESET_STATE;
      cnt   <= '0;
      evt   <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      evt   <= evt_nxt;
    end
  end
endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel switch/button debouncer.
//   clk   : system clock, all logic on posedge
//   reset : asynchronous, active-high reset
//   bus   : debounce_multi_if slave (sample_tk, raw_in in; db_state,
//           rise_pls, fall_pls, any_pls out)
// The interface instance must be parameterised with the same N_CH.
// Channels are fully independent; any_pls is registered from the same next-state
// pulse terms as the per-channel pulses so all of them assert in the same cycle.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = DB_DEFAULT_STABLE,
  parameter logic        RESET_STATE   = 1'b0
) (
  input logic              clk,
  input logic              reset,
  debounce_multi_if.slave  bus
);
  logic [N_CH-1:0] pls_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    db_evt_t evt;
    db_evt_t evt_nxt;

    debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_STATE   (RESET_STATE)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .sample_tk (bus.sample_tk),
      .raw       (bus.raw_in[i]),
      .state     (bus.db_state[i]),
      .evt       (evt),
      .evt_nxt   (evt_nxt)
    );

    assign bus.rise_pls[i] = evt.rise;
    assign bus.fall_pls[i] = evt.fall;
    assign pls_nxt[i]      = evt_nxt.rise | evt_nxt.fall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.any_pls <= 1'b0;
    end else begin
      bus.any_pls <= |pls_nxt;
    end
  end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: self-checking bench for debounce_multi (N_CH=4,
// STABLE_CYCLES=4, RESET_STATE=0). Expected pulse events are queued with the
// edge number at which they must appear; every clock the outputs are compared
// against the events due on that edge and a running model of the levels.
module tb_debounce_multi;
  localparam int LAT = 6; // negedge drive -> sampled next edge k -> flip at k+5

  typedef struct {
    int         due;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   edge_n = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t q[$];
  logic [3:0] exp_db = '0;
  logic [3:0] er, ef;

  debounce_multi_if #(.N_CH(4)) bus ();

  debounce_multi #(
    .N_CH          (4),
    .STABLE_CYCLES (4),
    .RESET_STATE   (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic push_exp(input int due, input logic [3:0] rise, input logic [3:0] fall);
    exp_t e;
    e.due = due; e.rise = rise; e.fall = fall;
    q.push_back(e);
  endtask

  // Collect events due on the current edge and advance the level model.
  task automatic pop_expected(output logic [3:0] r, output logic [3:0] f);
    r = '0; f = '0;
    while (q.size() > 0 && q[0].due == edge_n) begin
      r = r | q[0].rise;
      f = f | q[0].fall;
      exp_db = (exp_db | q[0].rise) & ~q[0].fall;
      void'(q.pop_front());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.raw_in = '0; bus.sample_tk = 1'b1;
    #1;
    n_total++;
    if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== 13'd0)
      $display("FAIL reset_init got db=%h r=%h f=%h any=%b exp all 0",
               bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls);
    else n_pass++;
    repeat (4) begin
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL reset_idle edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
      if (edge_n == 2) reset = 1'b0;
    end
    // raw high, then reset lands one edge before the flip would occur
    bus.raw_in = 4'hF;
    repeat (5) begin
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL reset_midcount edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL reset_held edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
    end
    reset = 1'b0;
    push_exp(edge_n + LAT, 4'hF, 4'h0);
    repeat (8) begin
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL reset_qualify edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
    end
    // asynchronous assert between edges must clear the level immediately
    #2 reset = 1'b1;
    #1;
    exp_db = '0;
    n_total++;
    if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== 13'd0)
      $display("FAIL reset_async got db=%h r=%h f=%h any=%b exp all 0",
               bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    push_exp(edge_n + LAT, 4'hF, 4'h0);
    repeat (8) begin
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL reset_requalify edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
    end
  endtask

  task automatic test_release();
    bus.raw_in = 4'h0;
    push_exp(edge_n + LAT, 4'h0, 4'hF);
    repeat (8) begin
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL release edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
    end
  endtask

  task automatic test_single_rise();
    bus.raw_in[0] = 1'b1;
    push_exp(edge_n + LAT, 4'b0001, 4'h0);
    repeat (8) begin
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL single_rise edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pattern;
    pattern = 6'b101101; // applied bit 0 first: 1,0,1,1,0,1 then held at 1
    for (int i = 0; i < 14; i++) begin
      if (i < 6) bus.raw_in[1] = pattern[i];
      if (i == 5) push_exp(edge_n + LAT, 4'b0010, 4'h0);
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL bounce edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 10; i++) begin
      bus.raw_in[2] = (i < 3);
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL glitch edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
    end
  endtask

  task automatic test_prescale();
    int k;
    int hits;
    int due;
    k = edge_n + 1;
    hits = 0;
    due = -1;
    // counting starts two edges after the raw sample (synchroniser depth)
    for (int e = k + 2; e < k + 40; e++) begin
      if (e % 3 == 0) begin
        hits++;
        if (hits == 4 && due < 0) due = e;
      end
    end
    bus.raw_in[3] = 1'b1;
    bus.sample_tk = ((edge_n + 1) % 3 == 0);
    push_exp(due, 4'b1000, 4'h0);
    repeat (20) begin
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL prescale edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
      bus.sample_tk = ((edge_n + 1) % 3 == 0);
    end
    bus.sample_tk = 1'b1;
  endtask

  task automatic test_simultaneous();
    bus.raw_in[0] = 1'b0;
    bus.raw_in[2] = 1'b1;
    push_exp(edge_n + LAT, 4'b0100, 4'b0001);
    repeat (9) begin
      @(negedge clk); pop_expected(er, ef);
      n_total++;
      if ({bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls} !== {exp_db, er, ef, |(er | ef)})
        $display("FAIL simultaneous edge=%0d got db=%h r=%h f=%h any=%b exp db=%h r=%h f=%h any=%b",
                 edge_n, bus.db_state, bus.rise_pls, bus.fall_pls, bus.any_pls, exp_db, er, ef, |(er | ef));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_single_rise();
    test_bounce();
    test_glitch();
    test_prescale();
    test_simultaneous();
    n_total++;
    if (q.size() != 0)
      $display("FAIL scoreboard_drain got %0d pending events, required 0", q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
